// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame admission, gap-free pixel streaming and output tracking for the layer-1 conv windower
module conv_frame_sequencer #(
    parameter int IMG_SIZE     = 32,
    parameter int CH_IN        = 3,
    parameter int GAP_CYCLES   = 34,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   frame_avail,
    input  logic                   src_vld,
    input  logic [CH_IN-1:0][15:0] src_data,
    output logic                   src_rdy,
    output logic                   conv_vld_in,
    output logic [CH_IN-1:0][15:0] conv_in,
    input  logic                   conv_vld_out,
    input  logic                   clr_err,
    output logic                   frame_start,
    output logic                   frame_done,
    output logic                   underrun,
    output logic                   busy
);
    localparam int NPIX = IMG_SIZE * IMG_SIZE;
    localparam int CW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam int OW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0] POS_LAST = CW'(IMG_SIZE - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(NPIX - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]    INF_MAX  = 3'(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          row_q, row_d, col_q, col_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [OW-1:0]          out_cnt_q, out_cnt_d;
    logic [2:0]             inflight_q, inflight_d;
    logic                   conv_vld_in_q, conv_vld_in_d;
    logic [CH_IN-1:0][15:0] conv_in_q, conv_in_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_done_q, frame_done_d;
    logic                   underrun_q, underrun_d;
    logic                   start_evt, done_evt, streaming;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            gap_cnt_q     <= '0;
            out_cnt_q     <= '0;
            inflight_q    <= '0;
            conv_vld_in_q <= 1'b0;
            conv_in_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            gap_cnt_q     <= gap_cnt_d;
            out_cnt_q     <= out_cnt_d;
            inflight_q    <= inflight_d;
            conv_vld_in_q <= conv_vld_in_d;
            conv_in_q     <= conv_in_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            underrun_q    <= underrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        gap_cnt_d = gap_cnt_q;
        out_cnt_d = out_cnt_q;
        start_evt = 1'b0;
        streaming = (state_q == STREAM);
        done_evt  = conv_vld_out && (inflight_q != 3'd0) && (out_cnt_q == OUT_LAST);

        case (state_q)
            IDLE: begin
                if (run && frame_avail && (inflight_q < INF_MAX)) begin
                    start_evt = 1'b1;
                    state_d   = STREAM;
                    row_d     = '0;
                    col_d     = '0;
                end
            end
            STREAM: begin
                // Runs a fixed pixel count regardless of src_vld so the windower never sees a hole.
                if (col_q == POS_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                    if (row_q == POS_LAST) begin
                        if (GAP_CYCLES > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_INIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Output beats with nothing in flight are stray and must not advance the count.
        if (conv_vld_out && (inflight_q != 3'd0)) begin
            out_cnt_d = done_evt ? '0 : out_cnt_q + 1'b1;
        end
        inflight_d = inflight_q + {2'b00, start_evt} - {2'b00, done_evt};

        conv_vld_in_d = streaming;
        conv_in_d     = (streaming && src_vld) ? src_data : '0;
        frame_start_d = streaming && (row_q == '0) && (col_q == '0);
        frame_done_d  = done_evt;
        underrun_d    = (streaming && !src_vld) || (underrun_q && !clr_err);
    end

    assign src_rdy     = (state_q == STREAM);
    assign busy        = (state_q != IDLE) || (inflight_q != 3'd0);
    assign conv_vld_in = conv_vld_in_q;
    assign conv_in     = conv_in_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign underrun    = underrun_q;
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - directed bench for conv_frame_sequencer at IMG_SIZE=4
module tb_conv_frame_sequencer;
    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0, run_b = 1'b0;
    logic             frame_avail = 1'b0;
    logic             src_vld = 1'b0;
    logic [2:0][15:0] src_data = '0;
    logic             conv_vld_out = 1'b0, conv_vld_out_b = 1'b0;
    logic             clr_err = 1'b0;

    logic             src_rdy, conv_vld_in, frame_start, frame_done, underrun, busy;
    logic [2:0][15:0] conv_in;
    logic             src_rdy_b, conv_vld_in_b, frame_start_b, frame_done_b, underrun_b, busy_b;
    logic [2:0][15:0] conv_in_b;

    int vecs = 0;
    int errs = 0;
    logic und_model = 1'b0;

    always #5 clock = ~clock;

    conv_frame_sequencer #(.IMG_SIZE(4), .CH_IN(3), .GAP_CYCLES(3), .MAX_INFLIGHT(2)) dut (
        .clock(clock), .reset(reset), .run(run), .frame_avail(frame_avail),
        .src_vld(src_vld), .src_data(src_data), .src_rdy(src_rdy),
        .conv_vld_in(conv_vld_in), .conv_in(conv_in), .conv_vld_out(conv_vld_out),
        .clr_err(clr_err), .frame_start(frame_start), .frame_done(frame_done),
        .underrun(underrun), .busy(busy)
    );

    conv_frame_sequencer #(.IMG_SIZE(4), .CH_IN(3), .GAP_CYCLES(0), .MAX_INFLIGHT(2)) dut_b (
        .clock(clock), .reset(reset), .run(run_b), .frame_avail(frame_avail),
        .src_vld(src_vld), .src_data(src_data), .src_rdy(src_rdy_b),
        .conv_vld_in(conv_vld_in_b), .conv_in(conv_in_b), .conv_vld_out(conv_vld_out_b),
        .clr_err(clr_err), .frame_start(frame_start_b), .frame_done(frame_done_b),
        .underrun(underrun_b), .busy(busy_b)
    );

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input string tag, input int max, input int exp_n);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!src_rdy && n < max);
        check(tag, 64'(n), 64'(exp_n));
    endtask

    // Entered on the negedge of the first STREAM cycle; leaves on the first GAP/IDLE negedge.
    task automatic stream_frame(input int base, input logic [15:0] drop);
        logic [63:0] exp_prev = '0;
        for (int i = 0; i < 16; i++) begin
            check("src_rdy_stream", src_rdy, 1'b1);
            if (i > 0) begin
                check("conv_vld_in", conv_vld_in, 1'b1);
                check("conv_in", 64'(conv_in), exp_prev);
                check("frame_start", frame_start, (i == 1));
                check("underrun", underrun, und_model);
            end else begin
                check("frame_start_pre", frame_start, 1'b0);
            end
            src_vld  = !drop[i];
            src_data = {3{16'(base + i)}};
            exp_prev = drop[i] ? 64'd0 : 64'({3{16'(base + i)}});
            cyc();
            if (drop[i]) und_model = 1'b1;
        end
        check("src_rdy_end", src_rdy, 1'b0);
        check("conv_vld_in_last", conv_vld_in, 1'b1);
        check("conv_in_last", 64'(conv_in), exp_prev);
        check("underrun_end", underrun, und_model);
        src_vld = 1'b1;
    endtask

    task automatic out_pulses(input int n, input int done_at);
        for (int k = 0; k < n; k++) begin
            conv_vld_out = 1'b1;
            cyc();
            check("frame_done", frame_done, (k == done_at));
        end
        conv_vld_out = 1'b0;
    endtask

    initial begin
        logic        seen_rdy;
        logic [32:0] pat;

        cyc();
        cyc();
        check("reset_outs", 64'({src_rdy, conv_vld_in, conv_in, frame_start, frame_done, underrun, busy}), 64'd0);
        reset = 1'b0;

        // Single frame, then gap + idle before the next admission
        run = 1'b1;
        frame_avail = 1'b1;
        src_vld = 1'b1;
        wait_rdy("first_start", 5, 1);
        stream_frame(32'h100, 16'h0000);
        wait_rdy("frame_period", 10, 4);

        // Underrun on pixels 5 and 6, then clear
        stream_frame(32'h200, 16'h0060);
        check("underrun_held", underrun, 1'b1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        und_model = 1'b0;
        check("underrun_cleared", underrun, 1'b0);

        // In-flight limit holds off the third frame
        seen_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (src_rdy) seen_rdy = 1'b1;
        end
        check("no_third_start", seen_rdy, 1'b0);
        check("busy_limited", busy, 1'b1);
        out_pulses(16, 15);
        wait_rdy("third_start", 5, 1);
        run = 1'b0;
        stream_frame(32'h300, 16'h0000);
        for (int i = 0; i < 6; i++) cyc();
        check("idle_rdy_low", src_rdy, 1'b0);
        check("busy_two_inflight", busy, 1'b1);

        // Frame completion on the same cycle as a new admission
        out_pulses(16, 15);
        out_pulses(15, -1);
        run = 1'b1;
        conv_vld_out = 1'b1;
        cyc();
        conv_vld_out = 1'b0;
        run = 1'b0;
        check("sim_done", frame_done, 1'b1);
        check("sim_start_rdy", src_rdy, 1'b1);
        stream_frame(32'h400, 16'h0000);
        for (int i = 0; i < 5; i++) cyc();
        check("busy_one_inflight", busy, 1'b1);
        out_pulses(16, 15);
        cyc();
        check("busy_drained", busy, 1'b0);

        // Asynchronous reset mid-frame
        run = 1'b1;
        wait_rdy("pre_reset_start", 5, 1);
        for (int i = 0; i < 7; i++) begin
            src_vld = (i != 6);
            cyc();
        end
        check("pre_reset_underrun", underrun, 1'b1);
        check("pre_reset_vld", conv_vld_in, 1'b1);
        #2 reset = 1'b1;
        #1 check("async_reset_outs", 64'({src_rdy, conv_vld_in, conv_in, frame_start, frame_done, underrun, busy}), 64'd0);
        src_vld = 1'b1;
        run = 1'b0;
        und_model = 1'b0;
        cyc();
        reset = 1'b0;
        out_pulses(3, -1);
        run = 1'b1;
        wait_rdy("post_reset_start", 5, 1);
        run = 1'b0;
        stream_frame(32'h500, 16'h0000);
        for (int i = 0; i < 5; i++) cyc();
        out_pulses(16, 15);

        // Zero-gap instance: back-to-back frames with one IDLE cycle between
        run_b = 1'b1;
        cyc();
        check("b_start", src_rdy_b, 1'b1);
        pat = '0;
        for (int j = 1; j <= 33; j++) begin
            cyc();
            pat[j-1] = conv_vld_in_b;
            if (j == 18) run_b = 1'b0;
        end
        check("b_vld_pattern", 64'(pat), 64'h1_FFFE_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller in front of the layer-1 convolution windower/SMM pipeline.
- The windower requires that once the first valid pixel of an image arrives, every following cycle of that image carries a valid pixel. This block provides that guarantee.
- It admits a frame only when upstream reports a complete frame buffered. It streams exactly IMG_SIZE*IMG_SIZE pixels back-to-back, zero-fills and flags any upstream underrun, and inserts a flush gap between frames.
- It also counts convolution outputs to report frame completion and limits the number of frames in flight.

Parameters:
- IMG_SIZE, 32, image width and height in pixels (square image).
- CH_IN, 3, input channels per pixel; each channel is 16 bits.
- GAP_CYCLES, 34, idle cycles forced between frames so the windower can flush; 0 is legal.
- MAX_INFLIGHT, 2, maximum number of frames that are started but not yet completed at the output; range 1..7.

Ports:
- clock, input, 1, single clock; all logic is on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- run, input, 1, enables starting new frames; sampled only in IDLE.
- frame_avail, input, 1, upstream holds at least one complete frame.
- src_vld, input, 1, upstream pixel valid.
- src_data, input, [CH_IN-1:0][15:0], upstream pixel.
- src_rdy, output, 1, pixel accepted this cycle when high.
- conv_vld_in, output, 1, drives the windower's vld_in.
- conv_in, output, [CH_IN-1:0][15:0], drives the windower's in.
- conv_vld_out, input, 1, vld_out of the convolution pipeline.
- clr_err, input, 1, clears the underrun flag.
- frame_start, output, 1, one-cycle pulse on the first pixel cycle of a frame.
- frame_done, output, 1, one-cycle pulse on the last output pixel of a frame.
- underrun, output, 1, sticky error flag.
- busy, output, 1, high when state != IDLE or inflight != 0.

Behaviour:
- Reset values (asynchronous): state=IDLE, all counters 0, and every output 0 (src_rdy, conv_vld_in, conv_in, frame_start, frame_done, underrun, busy).
- State machine: IDLE, STREAM, GAP.
- IDLE -> STREAM when run && frame_avail && inflight < MAX_INFLIGHT. In that same cycle: inflight+1, row=0, col=0.
- STREAM:
  - src_rdy = 1, combinational from state.
  - Each cycle advances col; when col == IMG_SIZE-1, col wraps to 0 and row+1.
  - On row == IMG_SIZE-1 && col == IMG_SIZE-1: go to GAP with gap_cnt = GAP_CYCLES-1 if GAP_CYCLES > 0, otherwise go directly to IDLE.
  - STREAM always lasts exactly IMG_SIZE*IMG_SIZE cycles, independent of src_vld.
- GAP: gap_cnt decrements each cycle; at 0 go to IDLE. src_rdy = 0.
- Datapath to the windower is registered, 1-cycle latency:
  - conv_vld_in <= (state == STREAM).
  - conv_in <= src_vld ? src_data : 0 while in STREAM; 0 otherwise.
- frame_start is registered and aligned with the first conv_vld_in of the frame.
- Underrun:
  - STREAM && !src_vld sets underrun (sticky). The zero pixel is still sent with conv_vld_in = 1, so the image never stalls.
  - clr_err clears underrun. If clr_err and a new underrun occur in the same cycle, set wins.
- Output tracking:
  - out_cnt counts conv_vld_out.
  - When conv_vld_out && out_cnt == IMG_SIZE*IMG_SIZE-1: out_cnt wraps to 0, frame_done pulses (registered, 1 cycle later), and inflight decrements.
  - If inflight increments and decrements in the same cycle, it is unchanged.
  - conv_vld_out while inflight == 0 is ignored: no count, no pulse.
- run deasserted mid-frame: the current frame completes and GAP completes; no new frame starts.
- frame_avail is checked only at IDLE exit.
- Counter widths: clog2(IMG_SIZE) for row and col; clog2(IMG_SIZE*IMG_SIZE) for out_cnt; 3 bits for inflight.
- Minimum frame period is IMG_SIZE*IMG_SIZE + GAP_CYCLES + 1 cycles (one IDLE cycle included).

Test Plan:
1. Single frame (IMG_SIZE=4, GAP_CYCLES=3, run=1, frame_avail=1, src_vld=1 with incrementing data) -> src_rdy high exactly 16 cycles; conv_vld_in high 16 consecutive cycles starting 1 cycle later; conv_in equals the data delayed by 1; frame_start pulses once with the first conv_vld_in; next src_rdy no earlier than 16+3+1 cycles after the first.
2. Underrun: drop src_vld on pixels 5 and 6 -> conv_vld_in stays high throughout; conv_in = 0 on those two cycles; underrun = 1 from the cycle after pixel 5 and held; one clr_err pulse -> 0.
3. In-flight limit (MAX_INFLIGHT=2, conv_vld_out held low) -> two frames stream, a third is not started, busy = 1; then drive 16 conv_vld_out -> frame_done pulses once, inflight drops to 1, and the third frame starts.
4. Simultaneous start and done: the 16th conv_vld_out coincides with the IDLE->STREAM cycle -> inflight unchanged; frame_done and frame_start both pulse.
5. Reset asserted mid-STREAM at pixel 7 -> all outputs 0 immediately (asynchronous); after release, the next frame starts at row 0, col 0 and delivers the full 16 pixels.
6. GAP_CYCLES=0, back-to-back frames -> conv_vld_in high 16 cycles, low 1 cycle (IDLE), then high 16 again.
